zube_z80_bus_ctrl: RTL and testbench
====================================

Name: zube_z80_bus_ctrl

Overview:
Z80-side bus cycle sequencer for the zube mailbox. It synchronises the asynchronous Z80 I/O strobes into the clk domain and decodes the port address against a base window. It sequences each Z80 I/O cycle into exactly one single-cycle register-bank read or write enable, and controls data-bus direction and turnaround. It also detects and counts protocol errors.

Parameters:
Z80_PORT_BASE, 8'h80, Z80 I/O base. Bits [7:2] select the window. Ports base+0..base+2 map to reg_sel 0..2. base+3 is reserved and ignored.
TIMEOUT_CYCLES, 1024, maximum clk cycles a read drive may last before it is forcibly released. Must be ≥4.

Ports:
clk  in  1  single clock (wishbone clock)
reset_b  in  1  asynchronous, active-low reset
z80_write_strobe_b  in  1  Z80 IO write strobe, active low, asynchronous
z80_read_strobe_b  in  1  Z80 IO read strobe, active low, asynchronous
z80_address_bus  in  8  Z80 port address, stable while a strobe is low
z80_data_bus_in  in  8  Z80 write data, stable while write strobe is low
z80_data_bus_out  out  8  registered read data driven to Z80
z80_bus_dir  out  1  1 = block drives Z80 data bus; gates pad output enables
reg_sel  out  2  register index for the current access
reg_wr_en  out  1  one-cycle write pulse to the register bank
reg_wr_data  out  8  latched write data, valid while reg_wr_en is high
reg_rd_en  out  1  one-cycle read pulse; the bank may clear-on-read
reg_rd_data  in  8  combinational bank read data, valid in the reg_rd_en cycle
busy  out  1  high whenever the FSM is not in IDLE
protocol_err  out  1  one-cycle pulse on each error event
err_count  out  8  saturating error counter

Behaviour:
- Reset (reset_b low, asynchronous): all outputs are 0, FSM is IDLE, and both synchroniser chains preset to 1 (inactive).
- Synchroniser: each strobe passes through 2 flops, giving wr_s and rd_s. Address and data are sampled directly; they are stable by construction because the synced strobe lags the pad by ≥2 cycles.
- hit: address[7:2]==Z80_PORT_BASE[7:2] and address[1:0]!=3.
- FSM states: IDLE, WR_PULSE, WR_HOLD, RD_PULSE, RD_DRIVE, IGNORE.
- IDLE, both wr_s and rd_s low: pulse protocol_err, go to IGNORE.
- IDLE, wr_s low only:
  - hit: latch reg_sel=address[1:0] and reg_wr_data=data_in, go to WR_PULSE.
  - no hit: go to IGNORE.
- IDLE, rd_s low only:
  - hit: latch reg_sel, go to RD_PULSE.
  - no hit: go to IGNORE.
- WR_PULSE: reg_wr_en=1 for exactly this cycle, then go to WR_HOLD.
- WR_HOLD: wait for wr_s high, then go to IDLE. If rd_s goes low here, pulse protocol_err and go to IGNORE.
- RD_PULSE: reg_rd_en=1 for exactly this cycle. At the end of the cycle, register z80_data_bus_out<=reg_rd_data, set z80_bus_dir<=1, and go to RD_DRIVE.
- RD_DRIVE: hold z80_data_bus_out and z80_bus_dir=1.
  - rd_s high: z80_bus_dir<=0, go to IDLE.
  - Timeout counter reaches TIMEOUT_CYCLES: z80_bus_dir<=0, pulse protocol_err, go to IGNORE.
  - wr_s low (contention): z80_bus_dir<=0, pulse protocol_err, go to IGNORE.
- IGNORE: no enables are issued. Wait until both wr_s and rd_s are high, then go to IDLE.
- Latency: strobe first sampled low at edge N gives enable high in the cycle after edge N+2. Read data appears on z80_data_bus_out and z80_bus_dir rises at edge N+3. A read strobe first sampled high at edge M drops z80_bus_dir at edge M+2.
- One Z80 cycle produces exactly one enable pulse, regardless of strobe length. Strobe glitches shorter than 1 clk cycle are unspecified. Bursts: a new access is accepted only after a return to IDLE, which requires ≥1 cycle with both strobes synced high.
- z80_data_bus_out retains its last value after release.
- err_count increments on each protocol_err and saturates at 8'hFF, with no wrap.
- Reset asserted mid-cycle forces z80_bus_dir=0 immediately, asynchronously. After reset releases with a strobe still low, the FSM starts in IDLE, sees the strobe, and performs the access once.

Test Plan:
- Write to port 0x81 with data 0xA5 and a 6-cycle strobe -> a single reg_wr_en pulse with reg_sel=1 and reg_wr_data=0xA5, 3 cycles after the first low sample; busy returns to 0 within 3 cycles after release.
- Read from port 0x82 with reg_rd_data=0x3C and a 10-cycle strobe -> one reg_rd_en pulse with reg_sel=2; z80_bus_dir rises at N+3 with z80_data_bus_out=0x3C; z80_bus_dir falls at M+2.
- Accesses to ports 0x83 and 0x40 (read and write) -> no reg_wr_en or reg_rd_en, z80_bus_dir stays 0, err_count stays 0.
- Both strobes asserted together, then a read held for TIMEOUT_CYCLES+5 -> err_count=2, z80_bus_dir deasserted at timeout, no enable on the first event.
- 300 back-to-back error events -> err_count saturates at 0xFF.
- reset_b pulsed low during RD_DRIVE -> z80_bus_dir=0 and err_count=0 with no clock edge; strobe still low at reset release -> exactly one new reg_rd_en pulse.

Source files
------------

// File: rtl/zube_z80_bus_ctrl.sv
// zube_z80_bus_ctrl
// -----------------
// Z80-side bus cycle sequencer for the zube mailbox. The asynchronous Z80 I/O
// strobes are synchronised into the clk domain. The port address is decoded
// against a four-port window, and each Z80 I/O cycle is turned into exactly one
// single-cycle register-bank read or write enable. The block also controls
// the data-bus direction, and it detects and counts protocol errors.
//
// Strobe/enable protocol: a Z80 cycle is "presented" while its synchronised
// strobe is low. The bank is "ready" unconditionally, so each accepted cycle
// produces exactly one reg_wr_en/reg_rd_en pulse. No further enable is issued
// until both synchronised strobes have been seen high again in IDLE.
//
// Ports:
//   clk, reset_b            clock, asynchronous active-low reset
//   z80_write_strobe_b      Z80 IORQ/WR write strobe (async, active low)
//   z80_read_strobe_b       Z80 IORQ/RD read strobe (async, active low)
//   z80_address_bus[7:0]    port address, stable while a strobe is low
//   z80_data_bus_in[7:0]    write data, stable while the write strobe is low
//   z80_data_bus_out[7:0]   registered read data towards the Z80
//   z80_bus_dir             1 = this block drives the Z80 data bus
//   reg_sel[1:0]            register index of the current access
//   reg_wr_en/reg_wr_data   one-cycle write pulse and latched write data
//   reg_rd_en/reg_rd_data   one-cycle read pulse and combinational bank data
//   busy                    FSM not in IDLE
//   protocol_err            one-cycle pulse per error event
//   err_count[7:0]          saturating error counter
//   dbg_state[2:0]          current FSM state, for observation only

module zube_z80_bus_ctrl #(
    parameter logic [7:0] Z80_PORT_BASE  = 8'h80,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       z80_write_strobe_b,
    input  logic       z80_read_strobe_b,
    input  logic [7:0] z80_address_bus,
    input  logic [7:0] z80_data_bus_in,
    output logic [7:0] z80_data_bus_out,
    output logic       z80_bus_dir,
    output logic [1:0] reg_sel,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       protocol_err,
    output logic [7:0] err_count,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_PULSE = 3'd1,
        ST_WR_HOLD  = 3'd2,
        ST_RD_PULSE = 3'd3,
        ST_RD_DRIVE = 3'd4,
        ST_IGNORE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    wr_sync_q, rd_sync_q;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          dir_q, dir_d;
    logic          err_q;
    logic          err_ev;
    logic [7:0]    err_cnt_q;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          wr_s, rd_s, hit;

    // Two-flop synchronisers, preset to the inactive (high) level so that a
    // strobe held low across reset release is seen as a fresh falling edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_sync_q <= 2'b11;
            rd_sync_q <= 2'b11;
        end else begin
            wr_sync_q <= {wr_sync_q[0], z80_write_strobe_b};
            rd_sync_q <= {rd_sync_q[0], z80_read_strobe_b};
        end
    end

    assign wr_s = wr_sync_q[1];
    assign rd_s = rd_sync_q[1];

    // Address and data are sampled without synchronisation: the synced strobe
    // lags the pad by at least two cycles, by which time both are stable.
    assign hit = (z80_address_bus[7:2] == Z80_PORT_BASE[7:2]) &&
                 (z80_address_bus[1:0] != 2'b11);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'b00;
            wr_data_q <= 8'h00;
            rd_data_q <= 8'h00;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            dir_q     <= dir_d;
            err_q     <= err_ev;
            to_cnt_q  <= to_cnt_d;
            if (err_ev && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        dir_d     = dir_q;
        to_cnt_d  = to_cnt_q;
        err_ev    = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!wr_s && !rd_s) begin
                    err_ev  = 1'b1;
                    state_d = ST_IGNORE;
                end else if (!wr_s) begin
                    if (hit) begin
                        sel_d     = z80_address_bus[1:0];
                        wr_data_d = z80_data_bus_in;
                        state_d   = ST_WR_PULSE;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else if (!rd_s) begin
                    if (hit) begin
                        sel_d   = z80_address_bus[1:0];
                        state_d = ST_RD_PULSE;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
            end

            ST_WR_PULSE: begin
                reg_wr_en = 1'b1;
                state_d   = ST_WR_HOLD;
            end

            ST_WR_HOLD: begin
                if (!rd_s) begin
                    err_ev  = 1'b1;
                    state_d = ST_IGNORE;
                end else if (wr_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_PULSE: begin
                // Bank data is captured in the enable cycle, so a
                // clear-on-read bank still returns the pre-clear value.
                reg_rd_en = 1'b1;
                rd_data_d = reg_rd_data;
                dir_d     = 1'b1;
                to_cnt_d  = '0;
                state_d   = ST_RD_DRIVE;
            end

            ST_RD_DRIVE: begin
                if (rd_s) begin
                    dir_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (!wr_s) begin
                    // The Z80 is driving the bus while we are: release at once.
                    dir_d   = 1'b0;
                    err_ev  = 1'b1;
                    state_d = ST_IGNORE;
                end else if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Drive has lasted TIMEOUT_CYCLES cycles.
                    dir_d   = 1'b0;
                    err_ev  = 1'b1;
                    state_d = ST_IGNORE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end

            ST_IGNORE: begin
                if (wr_s && rd_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign z80_data_bus_out = rd_data_q;
    assign z80_bus_dir      = dir_q;
    assign reg_sel          = sel_q;
    assign reg_wr_data      = wr_data_q;
    assign busy             = (state_q != ST_IDLE);
    assign protocol_err     = err_q;
    assign err_count        = err_cnt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_zube_z80_bus_ctrl.sv
// Directed testbench for zube_z80_bus_ctrl. Inputs change and outputs are
// checked 1 ns after each falling clock edge; a negedge monitor counts the
// enable, drive and error pulses.

module tb_zube_z80_bus_ctrl;

    localparam int TO = 32;

    logic       clk;
    logic       reset_b;
    logic       z80_write_strobe_b;
    logic       z80_read_strobe_b;
    logic [7:0] z80_address_bus;
    logic [7:0] z80_data_bus_in;
    logic [7:0] z80_data_bus_out;
    logic       z80_bus_dir;
    logic [1:0] reg_sel;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic       protocol_err;
    logic [7:0] err_count;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int dir_cnt  = 0;
    int perr_cnt = 0;
    logic [1:0] last_wr_sel;
    logic [7:0] last_wr_data;
    logic [1:0] last_rd_sel;

    zube_z80_bus_ctrl #(
        .Z80_PORT_BASE  (8'h80),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .reset_b            (reset_b),
        .z80_write_strobe_b (z80_write_strobe_b),
        .z80_read_strobe_b  (z80_read_strobe_b),
        .z80_address_bus    (z80_address_bus),
        .z80_data_bus_in    (z80_data_bus_in),
        .z80_data_bus_out   (z80_data_bus_out),
        .z80_bus_dir        (z80_bus_dir),
        .reg_sel            (reg_sel),
        .reg_wr_en          (reg_wr_en),
        .reg_wr_data        (reg_wr_data),
        .reg_rd_en          (reg_rd_en),
        .reg_rd_data        (reg_rd_data),
        .busy               (busy),
        .protocol_err       (protocol_err),
        .err_count          (err_count),
        .dbg_state          (dbg_state)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_sel  = reg_sel;
            last_wr_data = reg_wr_data;
        end
        if (reg_rd_en) begin
            rd_cnt      = rd_cnt + 1;
            last_rd_sel = reg_sel;
        end
        if (z80_bus_dir) dir_cnt = dir_cnt + 1;
        if (protocol_err) perr_cnt = perr_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Driver: one ignored-or-accepted access with a strobe of hold cycles.
    task automatic z80_access(input logic is_wr, input logic [7:0] addr, input int hold);
        z80_address_bus = addr;
        if (is_wr) z80_write_strobe_b = 1'b0;
        else       z80_read_strobe_b  = 1'b0;
        step(hold);
        z80_write_strobe_b = 1'b1;
        z80_read_strobe_b  = 1'b1;
        step(4);
    endtask

    task automatic err_event();
        z80_write_strobe_b = 1'b0;
        z80_read_strobe_b  = 1'b0;
        step(3);
        z80_write_strobe_b = 1'b1;
        z80_read_strobe_b  = 1'b1;
        step(3);
    endtask

    initial begin
        int base_dir;
        int base_rd;
        logic [7:0] ign_addr [2];
        ign_addr[0] = 8'h83;
        ign_addr[1] = 8'h40;

        reset_b            = 1'b0;
        z80_write_strobe_b = 1'b1;
        z80_read_strobe_b  = 1'b1;
        z80_address_bus    = 8'h00;
        z80_data_bus_in    = 8'h00;
        reg_rd_data        = 8'h00;
        step(3);

        // Reset state
        check_val("rst_dir",     {31'd0, z80_bus_dir}, 32'd0);
        check_val("rst_dout",    {24'd0, z80_data_bus_out}, 32'd0);
        check_val("rst_wr_en",   {31'd0, reg_wr_en}, 32'd0);
        check_val("rst_rd_en",   {31'd0, reg_rd_en}, 32'd0);
        check_val("rst_busy",    {31'd0, busy}, 32'd0);
        check_val("rst_perr",    {31'd0, protocol_err}, 32'd0);
        check_val("rst_errcnt",  {24'd0, err_count}, 32'd0);
        check_val("rst_sel",     {30'd0, reg_sel}, 32'd0);
        check_val("rst_wrdata",  {24'd0, reg_wr_data}, 32'd0);
        reset_b = 1'b1;
        step(3);

        // Write 0xA5 to port 0x81, 6-cycle strobe
        z80_address_bus    = 8'h81;
        z80_data_bus_in    = 8'hA5;
        z80_write_strobe_b = 1'b0;
        step(1);
        check_val("wr_en_N",   {31'd0, reg_wr_en}, 32'd0);
        step(1);
        check_val("wr_en_N1",  {31'd0, reg_wr_en}, 32'd0);
        step(1);
        check_val("wr_en_N2",  {31'd0, reg_wr_en}, 32'd1);
        check_val("wr_sel",    {30'd0, reg_sel}, 32'd1);
        check_val("wr_data",   {24'd0, reg_wr_data}, 32'hA5);
        step(1);
        check_val("wr_en_N3",  {31'd0, reg_wr_en}, 32'd0);
        check_val("wr_busy",   {31'd0, busy}, 32'd1);
        step(2);
        z80_write_strobe_b = 1'b1;
        z80_data_bus_in    = 8'h00;
        step(2);
        check_val("wr_busy_M1", {31'd0, busy}, 32'd1);
        step(1);
        check_val("wr_busy_M2", {31'd0, busy}, 32'd0);
        check_val("wr_count",   wr_cnt, 32'd1);

        // Read port 0x82, bank data 0x3C, 10-cycle strobe
        z80_address_bus   = 8'h82;
        reg_rd_data       = 8'h3C;
        z80_read_strobe_b = 1'b0;
        step(1);
        check_val("rd_en_N",   {31'd0, reg_rd_en}, 32'd0);
        step(2);
        check_val("rd_en_N2",  {31'd0, reg_rd_en}, 32'd1);
        check_val("rd_sel",    {30'd0, reg_sel}, 32'd2);
        check_val("rd_dir_N2", {31'd0, z80_bus_dir}, 32'd0);
        step(1);
        check_val("rd_en_N3",  {31'd0, reg_rd_en}, 32'd0);
        check_val("rd_dir_N3", {31'd0, z80_bus_dir}, 32'd1);
        check_val("rd_dout",   {24'd0, z80_data_bus_out}, 32'h3C);
        reg_rd_data = 8'h00;
        step(6);
        check_val("rd_dout_hold", {24'd0, z80_data_bus_out}, 32'h3C);
        z80_read_strobe_b = 1'b1;
        step(2);
        check_val("rd_dir_M1", {31'd0, z80_bus_dir}, 32'd1);
        step(1);
        check_val("rd_dir_M2", {31'd0, z80_bus_dir}, 32'd0);
        check_val("rd_dout_keep", {24'd0, z80_data_bus_out}, 32'h3C);
        check_val("rd_count",  rd_cnt, 32'd1);
        check_val("rd_dir_cycles", dir_cnt, 32'd9);

        // Ignored ports: 0x83 (reserved) and 0x40 (outside window)
        for (int a = 0; a < 2; a++) begin
            for (int k = 0; k < 2; k++) begin
                z80_address_bus = ign_addr[a];
                if (k == 0) z80_write_strobe_b = 1'b0;
                else        z80_read_strobe_b  = 1'b0;
                step(4);
                check_val("ign_state", {29'd0, dbg_state}, 32'd5);
                step(1);
                z80_write_strobe_b = 1'b1;
                z80_read_strobe_b  = 1'b1;
                step(4);
            end
        end
        check_val("ign_wr_cnt",  wr_cnt, 32'd1);
        check_val("ign_rd_cnt",  rd_cnt, 32'd1);
        check_val("ign_dir_cnt", dir_cnt, 32'd9);
        check_val("ign_errcnt",  {24'd0, err_count}, 32'd0);
        check_val("ign_busy",    {31'd0, busy}, 32'd0);

        // Both strobes together, then a read that runs into the timeout
        err_event();
        step(1);
        check_val("both_errcnt", {24'd0, err_count}, 32'd1);
        check_val("both_perr",   perr_cnt, 32'd1);
        check_val("both_wr_cnt", wr_cnt, 32'd1);
        check_val("both_rd_cnt", rd_cnt, 32'd1);

        base_dir          = dir_cnt;
        z80_address_bus   = 8'h80;
        reg_rd_data       = 8'h77;
        z80_read_strobe_b = 1'b0;
        step(TO + 5);
        check_val("to_dir",      {31'd0, z80_bus_dir}, 32'd0);
        check_val("to_errcnt",   {24'd0, err_count}, 32'd2);
        check_val("to_state",    {29'd0, dbg_state}, 32'd5);
        check_val("to_dout",     {24'd0, z80_data_bus_out}, 32'h77);
        check_val("to_rd_cnt",   rd_cnt, 32'd2);
        check_val("to_drive_len", dir_cnt - base_dir, TO);
        z80_read_strobe_b = 1'b1;
        step(4);
        check_val("to_busy",     {31'd0, busy}, 32'd0);
        check_val("to_rd_cnt2",  rd_cnt, 32'd2);

        // 300 back-to-back error events
        for (int i = 0; i < 250; i++) err_event();
        check_val("sat_mid",     {24'd0, err_count}, 32'hFC);
        for (int i = 0; i < 50; i++) err_event();
        check_val("sat_errcnt",  {24'd0, err_count}, 32'hFF);
        check_val("sat_perr",    perr_cnt, 32'd302);
        check_val("sat_wr_cnt",  wr_cnt, 32'd1);
        check_val("sat_rd_cnt",  rd_cnt, 32'd2);

        // Reset pulsed during RD_DRIVE, strobe still low at release
        z80_address_bus   = 8'h81;
        reg_rd_data       = 8'h5A;
        z80_read_strobe_b = 1'b0;
        step(5);
        check_val("rr_dir_pre",  {31'd0, z80_bus_dir}, 32'd1);
        check_val("rr_dout_pre", {24'd0, z80_data_bus_out}, 32'h5A);
        #1 reset_b = 1'b0;
        #1;
        check_val("rr_dir",      {31'd0, z80_bus_dir}, 32'd0);
        check_val("rr_errcnt",   {24'd0, err_count}, 32'd0);
        check_val("rr_dout",     {24'd0, z80_data_bus_out}, 32'd0);
        check_val("rr_busy",     {31'd0, busy}, 32'd0);
        #1 reset_b = 1'b1;
        base_rd = rd_cnt;
        step(3);
        check_val("rr_rd_en",    {31'd0, reg_rd_en}, 32'd1);
        step(1);
        check_val("rr_dir_N3",   {31'd0, z80_bus_dir}, 32'd1);
        check_val("rr_dout_N3",  {24'd0, z80_data_bus_out}, 32'h5A);
        step(4);
        z80_read_strobe_b = 1'b1;
        step(4);
        check_val("rr_rd_once",  rd_cnt - base_rd, 32'd1);
        check_val("rr_rd_sel",   {30'd0, last_rd_sel}, 32'd1);
        check_val("rr_dir_end",  {31'd0, z80_bus_dir}, 32'd0);
        check_val("rr_errcnt2",  {24'd0, err_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
